// File: rtl/ofifo_deskew.sv
// Output FIFO that re-aligns column-skewed partial sums into whole rows.
// One circular FIFO per column; a row can be popped only once every column holds an entry.
module ofifo_deskew #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [psum_bw*col-1:0]    in,
    input  logic [col-1:0]            wr,
    input  logic                      rd,
    output logic [psum_bw*col-1:0]    out,
    output logic                      rd_ack,
    output logic                      o_valid,
    output logic                      o_full,
    output logic                      o_ready,
    output logic [$clog2(depth):0]    o_count,
    output logic [col-1:0]            ovf,
    output logic                      udf
);

    localparam int aw = $clog2(depth);
    typedef logic [aw:0] ptr_t;
    localparam ptr_t full_lvl = ptr_t'(depth);
    localparam ptr_t ptr_one  = ptr_t'(1);

    ptr_t                 wr_ptr [col];
    ptr_t                 rd_ptr [col];
    ptr_t                 occ    [col];
    logic [col-1:0]       full;
    logic [col-1:0]       empty;
    logic [col-1:0]       wr_ok;
    logic                 pop;
    logic [psum_bw-1:0]   mem [col][depth];

    always_comb begin
        for (int c = 0; c < col; c++) begin
            occ[c]   = wr_ptr[c] - rd_ptr[c];
            full[c]  = (occ[c] == full_lvl);
            empty[c] = (occ[c] == '0);
            wr_ok[c] = wr[c] & ~full[c];
        end
    end

    // Handshake: a row is popped on a rising edge where rd && o_valid;
    // rd_ack is high for the next cycle only, and out holds that row until the next pop.
    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    always_comb begin
        o_count = full_lvl;
        for (int c = 0; c < col; c++) begin
            if (occ[c] < o_count) o_count = occ[c];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < col; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
            out    <= '0;
            rd_ack <= 1'b0;
            ovf    <= '0;
            udf    <= 1'b0;
        end else begin
            for (int c = 0; c < col; c++) begin
                if (wr_ok[c]) wr_ptr[c] <= wr_ptr[c] + ptr_one;
                // Fullness is judged at the start of the cycle, so a same-cycle pop does not rescue the write.
                if (wr[c] && full[c]) ovf[c] <= 1'b1;
                if (pop) begin
                    rd_ptr[c] <= rd_ptr[c] + ptr_one;
                    out[c*psum_bw +: psum_bw] <= mem[c][rd_ptr[c][aw-1:0]];
                end
            end
            rd_ack <= pop;
            if (rd && !o_valid) udf <= 1'b1;
        end
    end

    // Storage is left unreset: the cleared pointers make stale contents unreachable.
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (wr_ok[c]) mem[c][wr_ptr[c][aw-1:0]] <= in[c*psum_bw +: psum_bw];
        end
    end

endmodule

// File: tb/tb_ofifo_deskew.sv
// Randomised and directed bench for ofifo_deskew, checked against per-column queue model.
module tb_ofifo_deskew;

  localparam int COL   = 8;
  localparam int PW    = 16;
  localparam int DEPTH = 16;
  localparam int W     = PW * COL;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  din = '0;
  logic [COL-1:0] wr = '0;
  logic          rd = 1'b0;
  logic [W-1:0]  dout;
  logic          rd_ack, o_valid, o_full, o_ready, udf;
  logic [4:0]    o_count;
  logic [COL-1:0] ovf;

  int checks = 0;
  int failures = 0;

  // reference model: one data queue per column plus sticky flags
  logic [PW-1:0]  mq[COL][$];
  logic [COL-1:0] m_ovf = '0;
  logic           m_udf = 1'b0;
  logic           m_ack = 1'b0;
  logic [W-1:0]   m_out = '0;
  logic [W-1:0]   exp_q[$];

  ofifo_deskew #(.col(COL), .psum_bw(PW), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(din), .wr(wr), .rd(rd), .out(dout),
    .rd_ack(rd_ack), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready),
    .o_count(o_count), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic bit m_valid();
    for (int c = 0; c < COL; c++) if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_count();
    int mn = DEPTH;
    for (int c = 0; c < COL; c++) if (mq[c].size() < mn) mn = mq[c].size();
    return mn;
  endfunction

  function automatic bit m_full();
    for (int c = 0; c < COL; c++) if (mq[c].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < COL; c++) mq[c].delete();
    exp_q.delete();
    m_ovf = '0;
    m_udf = 1'b0;
    m_ack = 1'b0;
    m_out = '0;
  endtask

  // drive one cycle; model updates on the same edge using pre-edge occupancy
  task automatic step(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r);
    bit full_start[COL];
    bit pop;
    logic [W-1:0] row;
    wr = w; din = d; rd = r;
    @(posedge clk);
    pop = r && m_valid();
    if (r && !pop) m_udf = 1'b1;
    for (int c = 0; c < COL; c++) full_start[c] = (mq[c].size() == DEPTH);
    if (pop) begin
      for (int c = 0; c < COL; c++) row[c*PW +: PW] = mq[c].pop_front();
      m_out = row;
      exp_q.push_back(row);
    end
    for (int c = 0; c < COL; c++) begin
      if (w[c]) begin
        if (full_start[c]) m_ovf[c] = 1'b1;
        else mq[c].push_back(d[c*PW +: PW]);
      end
    end
    m_ack = pop;
    #2;
    wr = '0; rd = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] v;
    for (int c = 0; c < COL; c++) v[c*PW +: PW] = PW'($urandom);
    return v;
  endfunction

  function automatic logic [W-1:0] const_row(input logic [PW-1:0] base, input bit add_col);
    logic [W-1:0] v;
    for (int c = 0; c < COL; c++) v[c*PW +: PW] = base + (add_col ? PW'(c) : PW'(0));
    return v;
  endfunction

  // asynchronous pulse between edges; outputs must clear before any edge
  task automatic pulse_reset();
    #1 reset = 1'b1;
    model_clear();
    #1;
    chk("rst_o_valid", W'(o_valid), W'(0));
    chk("rst_o_count", W'(o_count), W'(0));
    chk("rst_ovf", W'(ovf), W'(0));
    chk("rst_udf", W'(udf), W'(0));
    chk("rst_o_ready", W'(o_ready), W'(1));
    chk("rst_rd_ack", W'(rd_ack), W'(0));
    chk("rst_out", dout, W'(0));
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  // monitor: status against model every cycle, popped row against scoreboard on rd_ack
  always @(negedge clk) begin
    logic [W-1:0] exp_row;
    chk("o_valid", W'(o_valid), W'(m_valid()));
    chk("o_count", W'(o_count), W'(m_count()));
    chk("o_full", W'(o_full), W'(m_full()));
    chk("o_ready", W'(o_ready), W'(!m_full()));
    chk("ovf", W'(ovf), W'(m_ovf));
    chk("udf", W'(udf), W'(m_udf));
    chk("rd_ack", W'(rd_ack), W'(m_ack));
    chk("out_hold", dout, m_out);
    if (rd_ack) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL pop_row act=%h exp=none", dout);
      end else begin
        exp_row = exp_q.pop_front();
        chk("pop_row", dout, exp_row);
      end
    end
  end

  initial begin
    logic [W-1:0] v;
    model_clear();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // skewed fill: column c written at cycle c
    for (int c = 0; c < COL; c++) begin
      chk("skew_no_valid", W'(o_valid), W'(0));
      step(COL'(1 << c), const_row(16'h0100, 1'b1), 1'b0);
    end
    chk("skew_valid", W'(o_valid), W'(1));
    chk("skew_count", W'(o_count), W'(1));
    step('0, '0, 1'b1);
    v = const_row(16'h0100, 1'b1);
    chk("skew_out", dout, v);
    chk("skew_ack", W'(rd_ack), W'(1));
    chk("skew_valid_after", W'(o_valid), W'(0));
    pulse_reset();

    // full and overflow, then drain in order
    for (int i = 0; i < DEPTH; i++) step('1, rand_row(), 1'b0);
    chk("full_o_full", W'(o_full), W'(1));
    chk("full_o_ready", W'(o_ready), W'(0));
    chk("full_count", W'(o_count), W'(16));
    step(8'h08, rand_row(), 1'b0);
    chk("ovf_col3", W'(ovf), W'(8'h08));
    for (int i = 0; i < DEPTH; i++) step('0, '0, 1'b1);

    // underflow on empty
    v = dout;
    step('0, '0, 1'b1);
    chk("udf_set", W'(udf), W'(1));
    chk("udf_no_ack", W'(rd_ack), W'(0));
    chk("udf_out_hold", dout, v);
    pulse_reset();

    // wrap-around streaming with simultaneous write and pop
    step('1, const_row(16'd0, 1'b0), 1'b0);
    for (int i = 1; i < 40; i++) step('1, const_row(PW'(i), 1'b0), 1'b1);
    step('0, '0, 1'b1);
    chk("wrap_ovf", W'(ovf), W'(0));
    chk("wrap_udf", W'(udf), W'(0));
    chk("wrap_empty", W'(o_valid), W'(0));

    // simultaneous: col0 full, col1 not full, both written while popping
    for (int i = 0; i < DEPTH - 1; i++) step('1, rand_row(), 1'b0);
    step(8'h01, rand_row(), 1'b0);
    step(8'h03, rand_row(), 1'b1);
    chk("simul_ovf", W'(ovf), W'(8'h01));
    chk("simul_count", W'(o_count), W'(14));
    chk("simul_not_full", W'(o_full), W'(0));
    pulse_reset();

    // reset mid-fill, then only new data pops
    for (int i = 0; i < 5; i++) step('1, rand_row(), 1'b0);
    pulse_reset();
    v = rand_row();
    step('1, v, 1'b0);
    step('0, '0, 1'b1);
    chk("post_rst_row", dout, v);
    pulse_reset();

    // random traffic with independent per-column skew
    for (int i = 0; i < 600; i++) begin
      logic [COL-1:0] w;
      for (int c = 0; c < COL; c++) w[c] = ($urandom_range(0, 99) < 55);
      step(w, rand_row(), ($urandom_range(0, 99) < 45));
    end
    for (int i = 0; i < DEPTH + 2; i++) step('0, '0, 1'b1);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", W'(exp_q.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ofifo_deskew.md
OFIFO_DESKEW -- requirements
Module: ofifo_deskew

Interface
REQ-001 SHALL have parameter col, default 8: number of columns, equal to the array column count.
REQ-002 SHALL have parameter psum_bw, default 16: partial-sum width per column.
REQ-003 SHALL have parameter depth, default 16: entries per column FIFO; a power of 2, at least 4.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in, input, psum_bw*col: column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c]; driven by the array out_s.
REQ-007 SHALL have port wr, input, col: per-column write strobe; driven by the array per-column valid, which is skewed in time across columns.
REQ-008 SHALL have port rd, input, 1: request to pop one complete row.
REQ-009 SHALL have port out, output, psum_bw*col: registered row data, with the same column packing as in.
REQ-010 SHALL have port rd_ack, output, 1: one-cycle pulse marking out as newly updated.
REQ-011 SHALL have port o_valid, output, 1: at least one complete row is stored.
REQ-012 SHALL have port o_full, output, 1: at least one column FIFO is full.
REQ-013 SHALL have port o_ready, output, 1: no column FIFO is full.
REQ-014 SHALL have port o_count, output, log2(depth)+1: number of complete rows stored.
REQ-015 SHALL have port ovf, output, col: sticky per-column overflow flags.
REQ-016 SHALL have port udf, output, 1: sticky underflow flag.

Function
REQ-017 SHALL hold one independent circular FIFO per column, with wr_ptr and rd_ptr each log2(depth)+1 bits, including a wrap bit.
REQ-018 SHALL compute per column: occupancy = wr_ptr - rd_ptr (modulo 2^(log2(depth)+1)); empty when occupancy==0; full when occupancy==depth.
REQ-019 SHALL write in[c] to column c and increment wr_ptr[c] when wr[c]=1 and column c was not full at the start of the cycle.
REQ-020 SHALL drop the data when wr[c]=1 and column c is full, leave the pointers unchanged, and set ovf[c]; this holds even if a pop of the same column occurs in that cycle.
REQ-021 SHALL drive o_valid as the AND of all column not-empty flags, combinationally from the registered pointers.
REQ-022 SHALL drive o_full as the OR of the column full flags, and o_ready as NOT o_full.
REQ-023 SHALL drive o_count as the minimum occupancy across columns, combinationally.
REQ-024 SHALL accept a pop when rd=1 and o_valid=1; on acceptance every column rd_ptr increments in the same edge.
REQ-025 SHALL, on an accepted pop, load out with the head entry of every column on that edge, and assert rd_ack for exactly the following cycle.
REQ-026 SHALL, when rd=1 and o_valid=0, leave the pointers and out unchanged, keep rd_ack at 0, and set udf.
REQ-027 SHALL provide no bypass: a write to an empty column becomes visible to o_valid one cycle after the write edge.
REQ-028 SHALL allow a simultaneous write and accepted pop on the same non-full column, leaving that column's occupancy unchanged.
REQ-029 SHALL hold out between accepted pops.
REQ-030 SHALL wrap the pointers naturally, with no loss of data across the depth boundary.
REQ-031 SHALL allow arbitrary skew between columns: partial rows never assert o_valid, and columns may lead one another by up to depth entries.

Reset
REQ-032 SHALL, while reset=1 (asynchronously), clear all pointers, out, rd_ack, ovf and udf to 0, so that o_valid=0, o_full=0, o_ready=1 and o_count=0.
REQ-033 SHALL discard all stored entries when reset asserts mid-operation; no data written before reset is ever popped afterwards.
REQ-034 SHALL ignore wr and rd in the first edge where reset is sampled 1, and resume normal operation on the first edge after reset deasserts.

Verification
REQ-035 SHALL cover skewed fill: col=8, wr[c] asserted at cycle c with in[c]=16'h0100+c -> o_valid stays 0 through cycle 7, rises at cycle 8 with o_count=1; rd -> out = {16'h0107 ... 16'h0100}, rd_ack=1 for one cycle, o_valid returns to 0.
REQ-036 SHALL cover full and overflow: 16 writes on all columns -> o_full=1, o_ready=0, o_count=16; a 17th write on column 3 -> ovf=8'h08 and contents unchanged; 16 pops return the data in order.
REQ-037 SHALL cover underflow: rd=1 on an empty FIFO -> udf=1, rd_ack=0, out unchanged, pointers unchanged.
REQ-038 SHALL cover wrap-around: 40 rows streamed with simultaneous write and pop, each data value = row index -> every popped row matches in order, with no ovf or udf.
REQ-039 SHALL cover simultaneous events: full column plus write plus pop in the same cycle -> write dropped, ovf set, occupancy becomes 15; non-full column plus write plus pop -> occupancy unchanged.
REQ-040 SHALL cover reset mid-fill: 5 rows stored, then reset pulsed asynchronously between edges -> o_valid=0, o_count=0, ovf=0 and udf=0 immediately; a subsequent row pops only the new data.
